// File: rtl/uart_transmitter.sv
// UART transmitter: 8N1 framing with optional even parity, CLKS_PER_BIT clocks per bit.
// Every output is registered and updated on the same edge as the state that it reflects.
module uart_transmitter #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       txStart,
  input  logic [7:0] data_in,
  input  logic       parity_en,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state_q;
  logic [TW-1:0] timer_q;
  logic [2:0]    index_q;
  logic [7:0]    data_q;
  logic          parity_en_q;
  logic          tx_q;
  logic          busy_q;
  logic          done_q;
  logic          bit_end;

  assign bit_end = (timer_q == TW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      index_q     <= '0;
      data_q      <= '0;
      parity_en_q <= 1'b0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == IDLE) begin
        timer_q <= '0;
        index_q <= '0;
        if (txStart) begin
          data_q      <= data_in;
          parity_en_q <= parity_en;
          state_q     <= START;
          tx_q        <= 1'b0;
          busy_q      <= 1'b1;
        end
      end else begin
        timer_q <= bit_end ? '0 : timer_q + 1'b1;
        // The tx value for the next bit is loaded on the same edge the state advances.
        if (bit_end) begin
          case (state_q)
            START: begin
              state_q <= DATA;
              index_q <= '0;
              tx_q    <= data_q[0];
            end
            DATA: begin
              if (index_q == 3'd7) begin
                if (parity_en_q) begin
                  state_q <= PARITY;
                  tx_q    <= ^data_q;
                end else begin
                  state_q <= STOP;
                  tx_q    <= 1'b1;
                end
              end else begin
                index_q <= index_q + 3'd1;
                tx_q    <= data_q[index_q + 3'd1];
              end
            end
            PARITY: begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end
            STOP: begin
              state_q <= IDLE;
              tx_q    <= 1'b1;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
            default: begin
              state_q <= IDLE;
              tx_q    <= 1'b1;
              busy_q  <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clock cycles per serial bit, legal range 2..1023.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
REQ-004 txStart  input  1  request to send one frame, level-sampled, accepted only in IDLE.
REQ-005 data_in  input  8  byte to transmit, captured in the accept cycle.
REQ-006 parity_en  input  1  1 = append even-parity bit, captured in the accept cycle.
REQ-007 tx  output  1  serial line, registered, idle high.
REQ-008 busy  output  1  high while a frame is in progress (START..STOP).
REQ-009 done  output  1  one-cycle pulse marking frame completion.

Function
REQ-010 Frame format: start bit 0, data_in[0]..data_in[7] LSB first, optional parity bit, stop bit 1.
REQ-011 Parity bit is XOR of the 8 captured data bits (even parity), sent only when captured parity_en=1.
REQ-012 States: IDLE, START, DATA, PARITY, STOP; all are registered.
REQ-013 IDLE: tx=1, busy=0; txStart=1 at an edge -> capture data_in/parity_en, go START, clear bit-timer and bit index.
REQ-014 START: tx=0 for exactly CLKS_PER_BIT cycles, then go DATA.
REQ-015 DATA: tx=captured bit[index] for CLKS_PER_BIT cycles each; index 0..7; after index 7 -> PARITY if parity captured, else STOP.
REQ-016 PARITY: tx=parity bit for CLKS_PER_BIT cycles, then go STOP.
REQ-017 STOP: tx=1 for CLKS_PER_BIT cycles, then go IDLE with done=1 for exactly that first IDLE cycle.
REQ-018 Latency: tx falls in the first cycle after the accepting edge; busy rises in the same cycle.
REQ-019 Frame length: 10*CLKS_PER_BIT cycles without parity, 11*CLKS_PER_BIT cycles with parity.
REQ-020 Bit-timer counts 0..CLKS_PER_BIT-1 and wraps; the state/bit advance occurs on the wrap.
REQ-021 txStart while busy=1 is ignored; data_in and parity_en changes mid-frame have no effect.
REQ-022 txStart=1 in the done cycle is accepted; next start bit begins the following cycle, giving back-to-back frames with a 1-cycle idle-high gap.
REQ-023 txStart held high continuously produces consecutive frames, each re-capturing data_in at its accept cycle.
REQ-024 done and busy are never high in the same cycle.

Reset
REQ-025 rst_n=0 at an edge forces IDLE, tx=1, busy=0, done=0, and clears timer, index and captured data.
REQ-026 Reset mid-frame aborts the frame in the next cycle: tx=1, no done pulse is generated.
REQ-027 While rst_n=0, txStart is ignored; the first accept is possible on the first edge with rst_n=1.

Verification
REQ-028 CLKS_PER_BIT=16, parity_en=0, data_in=0x55, one-cycle txStart -> tx bits 0,1,0,1,0,1,0,1,0,1 each 16 cycles; busy high 160 cycles; done pulses once.
REQ-029 parity_en=1, data_in=0xA7 -> data bits 1,1,1,0,0,1,0,1, parity bit 1, stop 1; busy high 176 cycles.
REQ-030 parity_en=1, data_in=0x03 -> parity bit 0; loopback into the team's Receiver with PARITY_CHECK -> out=0x03, parity_err=0, done=1.
REQ-031 txStart pulsed at cycle 40 of a frame with data_in=0xFF -> ignored; the frame in progress is unchanged and only one done pulse occurs.
REQ-032 txStart held high with data_in=0x12 then 0x34 -> two frames separated by exactly one idle-high cycle, bytes 0x12 then 0x34.
REQ-033 rst_n=0 for one cycle during DATA bit 3 -> tx=1, busy=0 the next cycle, no done pulse; a new txStart then sends a complete frame.
